// File: rtl/mem_store_buffer_pkg.sv
// Shared definitions for the posted-store buffer in front of the data memory:
// store opcodes, store-entry payload, drain-control state encoding.
// No ports (package).
package mips_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 6;

    localparam logic [OPC_W-1:0] OP_SB = 6'h28;
    localparam logic [OPC_W-1:0] OP_SH = 6'h29;
    localparam logic [OPC_W-1:0] OP_SW = 6'h2B;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [OPC_W-1:0]  opcode;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FULL  = 2'd2
    } drain_state_t;

    // True for the three store opcodes the buffer accepts.
    function automatic logic is_store_op(input logic [OPC_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_store_buffer_if.sv
// Bus bundle for the store buffer: MEM-stage store and load ports, data
// memory write port, and occupancy.
//   slave  : the store buffer side
//   master : the pipeline / memory side (testbench)
interface mem_store_buffer_if
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // store port from MEM stage
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [OPC_W-1:0]  st_opcode;
    // load check port
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              ld_stall;
    // data memory write port
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [OPC_W-1:0]  mem_opcode;
    // occupancy
    logic [CNT_W-1:0]  count;

    modport slave (
        input  st_valid, st_addr, st_data, st_opcode,
        output st_ready,
        input  ld_valid, ld_addr,
        output ld_hit, ld_data, ld_stall,
        output mem_wr_valid, mem_addr, mem_wdata, mem_opcode,
        input  mem_wr_ready,
        output count
    );

    modport master (
        output st_valid, st_addr, st_data, st_opcode,
        input  st_ready,
        output ld_valid, ld_addr,
        input  ld_hit, ld_data, ld_stall,
        input  mem_wr_valid, mem_addr, mem_wdata, mem_opcode,
        output mem_wr_ready,
        input  count
    );

endinterface

// File: rtl/mem_store_buffer_match.sv
// sb_match_unit: compares a load address against every valid store entry and
// reports whether any matches plus the index of the youngest matching entry.
// Ports:
//   valid_i   per-entry valid bits
//   addr_i    per-entry word addresses
//   head_i    head pointer (oldest entry); defines age order
//   ld_addr_i load word address
//   hit_o     at least one valid entry matches
//   idx_o     youngest matching entry index (0 when no hit)
module sb_match_unit
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
    input  logic [$clog2(DEPTH)-1:0]     head_i,
    input  logic [ADDR_W-1:0]            ld_addr_i,
    output logic                         hit_o,
    output logic [$clog2(DEPTH)-1:0]     idx_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] pos;

    // Walk oldest to youngest from head; the last match seen is the youngest.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        pos   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pos = head_i + PTR_W'(i);
            if (valid_i[pos] && (addr_i[pos] == ld_addr_i)) begin
                hit_o = 1'b1;
                idx_o = pos;
            end
        end
    end

endmodule

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: posted-store FIFO in front of the word-addressed data
// memory. Stores (sb/sh/sw) are queued and drained one per memory handshake;
// loads are checked against pending stores so they never see stale data.
// Optional feature macro: STORE_FWD_EN
//   defined   -> a load whose youngest matching entry is a sw is forwarded
//   undefined -> any matching entry stalls the load; ld_hit/ld_data tied 0
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-high; discards all entries
//   bus    mem_store_buffer_if.slave (store, load, memory write, count)
module mem_store_buffer
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_store_buffer_if.slave     bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    drain_state_t          state_q, state_d;

    logic                        st_ready_c;
    logic                        enq;
    logic                        deq;
    logic [DEPTH-1:0]            entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
    logic                        match_hit;
    logic [PTR_W-1:0]            match_idx;
    logic                        ld_hit_c;
    logic                        ld_stall_c;
    logic [DATA_W-1:0]           ld_data_c;

    // Handshake qualifiers; the FSM state mirrors empty/full occupancy.
    assign st_ready_c = (state_q != ST_FULL);
    assign enq        = bus.st_valid && st_ready_c && is_store_op(bus.st_opcode);
    assign deq        = (state_q != ST_IDLE) && bus.mem_wr_ready;

    // Queue next-state: pointers, count and entry contents.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q + PTR_W'(deq);
        tail_d    = tail_q + PTR_W'(enq);
        count_d   = count_q;
        if (deq) begin
            entries_d[head_q].valid = 1'b0;
        end
        // enq and deq never target the same slot: full blocks enq, empty blocks deq
        if (enq) begin
            entries_d[tail_q].valid  = 1'b1;
            entries_d[tail_q].addr   = bus.st_addr;
            entries_d[tail_q].data   = bus.st_data;
            entries_d[tail_q].opcode = bus.st_opcode;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Drain control next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enq) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == CNT_W'(DEPTH)) begin
                    state_d = ST_FULL;
                end else if (count_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (deq) begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
        end
    end

    // Flatten entry fields needed by the matcher.
    always_comb begin
        entry_valid = '0;
        entry_addr  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_valid[i] = entries_q[i].valid;
            entry_addr[i]  = entries_q[i].addr;
        end
    end

    sb_match_unit #(
        .DEPTH (DEPTH)
    ) u_match (
        .valid_i   (entry_valid),
        .addr_i    (entry_addr),
        .head_i    (head_q),
        .ld_addr_i (bus.ld_addr),
        .hit_o     (match_hit),
        .idx_o     (match_idx)
    );

    // Load check against registered entries only, so a same-cycle enqueue is
    // not seen while a same-cycle dequeuing head still is.
`ifdef STORE_FWD_EN
    always_comb begin
        ld_hit_c   = 1'b0;
        ld_stall_c = 1'b0;
        ld_data_c  = '0;
        if (bus.ld_valid && match_hit) begin
            if (entries_q[match_idx].opcode == OP_SW) begin
                ld_hit_c  = 1'b1;
                ld_data_c = entries_q[match_idx].data;
            end else begin
                // partial-word store: memory must merge it first
                ld_stall_c = 1'b1;
            end
        end
    end
`else
    logic unused_match_idx;
    assign unused_match_idx = ^match_idx;

    always_comb begin
        ld_hit_c   = 1'b0;
        ld_data_c  = '0;
        ld_stall_c = bus.ld_valid && match_hit;
    end
`endif

    assign bus.st_ready     = st_ready_c;
    assign bus.ld_hit       = ld_hit_c;
    assign bus.ld_stall     = ld_stall_c;
    assign bus.ld_data      = ld_data_c;
    assign bus.mem_wr_valid = (state_q != ST_IDLE);
    assign bus.mem_addr     = entries_q[head_q].addr;
    assign bus.mem_wdata    = entries_q[head_q].data;
    assign bus.mem_opcode   = entries_q[head_q].opcode;
    assign bus.count        = count_q;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed self-checking bench for mem_store_buffer (DEPTH=4).
// Expected values follow either build of STORE_FWD_EN.
module tb_mem_store_buffer;
    import mips_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] wr_log[$];

    mem_store_buffer_if #(.DEPTH(4)) bus ();

    mem_store_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted memory write address.
    always @(posedge clk) begin
        if (bus.mem_wr_valid && bus.mem_wr_ready) begin
            wr_log.push_back(bus.mem_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        bus.st_valid  = 1'b1;
        bus.st_opcode = op;
        bus.st_addr   = a;
        bus.st_data   = d;
        tick();
        bus.st_valid  = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.count !== 3'd0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", bus.count);
        end
        checks++;
        if (bus.mem_wr_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mem_wr_valid got %b exp 0", bus.mem_wr_valid);
        end
        checks++;
        if (bus.st_ready !== 1'b1) begin
            errors++; $display("FAIL reset_st_ready got %b exp 1", bus.st_ready);
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_mem_data got %h/%h exp 0/0", bus.mem_addr, bus.mem_wdata);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.count !== 3'd0 || bus.mem_wr_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset got count %0d valid %b exp 0 0", bus.count, bus.mem_wr_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        bus.mem_wr_ready = 1'b0;
        push(OP_SW, 32'h1, 32'h11);
        push(OP_SW, 32'h2, 32'h22);
        push(OP_SW, 32'h3, 32'h33);
        checks++;
        if (bus.count !== 3'd3 || bus.mem_wr_valid !== 1'b1 || bus.mem_addr !== 32'h1) begin
            errors++; $display("FAIL mid_drain_pre got count %0d valid %b addr %h exp 3 1 1",
                               bus.count, bus.mem_wr_valid, bus.mem_addr);
        end
        wr_log.delete();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.count !== 3'd0 || bus.mem_wr_valid !== 1'b0) begin
            errors++; $display("FAIL mid_drain_async got count %0d valid %b exp 0 0", bus.count, bus.mem_wr_valid);
        end
        bus.mem_wr_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (wr_log.size() != 0 || bus.count !== 3'd0) begin
            errors++; $display("FAIL mid_drain_writes got %0d writes count %0d exp 0 0", wr_log.size(), bus.count);
        end
        bus.mem_wr_ready = 1'b0;
    endtask

    task automatic test_fill();
        logic [31:0] exp_a;
        wr_log.delete();
        bus.mem_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(OP_SW, 32'h100 + 32'(i), 32'hA0 + 32'(i));
        end
        checks++;
        if (bus.count !== 3'd4 || bus.st_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full got count %0d ready %b exp 4 0", bus.count, bus.st_ready);
        end
        // fifth store waits
        bus.st_valid  = 1'b1;
        bus.st_opcode = OP_SW;
        bus.st_addr   = 32'h104;
        bus.st_data   = 32'hA4;
        tick();
        checks++;
        if (bus.count !== 3'd4 || bus.mem_wdata !== 32'hA0) begin
            errors++; $display("FAIL fill_held got count %0d wdata %h exp 4 a0", bus.count, bus.mem_wdata);
        end
        bus.mem_wr_ready = 1'b1;
        tick();
        checks++;
        if (bus.count !== 3'd3 || bus.st_ready !== 1'b1 || wr_log.size() != 1) begin
            errors++; $display("FAIL fill_first_deq got count %0d ready %b writes %0d exp 3 1 1",
                               bus.count, bus.st_ready, wr_log.size());
        end
        tick();
        bus.st_valid = 1'b0;
        checks++;
        if (bus.count !== 3'd3) begin
            errors++; $display("FAIL fill_enq_deq got count %0d exp 3", bus.count);
        end
        for (int i = 0; i < 20 && bus.count !== 3'd0; i++) tick();
        checks++;
        if (bus.count !== 3'd0 || wr_log.size() != 5) begin
            errors++; $display("FAIL fill_drain got count %0d writes %0d exp 0 5", bus.count, wr_log.size());
        end
        for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
            exp_a = 32'h100 + 32'(i);
            checks++;
            if (wr_log[i] !== exp_a) begin
                errors++; $display("FAIL fill_order[%0d] got %h exp %h", i, wr_log[i], exp_a);
            end
        end
        bus.mem_wr_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  max_cnt;
        logic [31:0] exp_a;
        wr_log.delete();
        max_cnt = '0;
        bus.mem_wr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.st_valid  = 1'b1;
            bus.st_opcode = OP_SW;
            bus.st_addr   = 32'h200 + 32'(i);
            bus.st_data   = 32'(i);
            tick();
            if (bus.count > max_cnt) max_cnt = bus.count;
        end
        bus.st_valid = 1'b0;
        tick();
        checks++;
        if (max_cnt !== 3'd1) begin
            errors++; $display("FAIL b2b_max_count got %0d exp 1", max_cnt);
        end
        checks++;
        if (bus.count !== 3'd0 || wr_log.size() != 10) begin
            errors++; $display("FAIL b2b_drain got count %0d writes %0d exp 0 10", bus.count, wr_log.size());
        end
        for (int i = 0; i < 10 && i < wr_log.size(); i++) begin
            exp_a = 32'h200 + 32'(i);
            checks++;
            if (wr_log[i] !== exp_a) begin
                errors++; $display("FAIL b2b_order[%0d] got %h exp %h", i, wr_log[i], exp_a);
            end
        end
        bus.mem_wr_ready = 1'b0;
    endtask

    task automatic test_forward();
        bus.mem_wr_ready = 1'b0;
        push(OP_SW, 32'h10, 32'hDEADBEEF);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h10;
        #1;
`ifdef STORE_FWD_EN
        checks++;
        if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'hDEADBEEF || bus.ld_stall !== 1'b0) begin
            errors++; $display("FAIL fwd_hit got hit %b data %h stall %b exp 1 deadbeef 0",
                               bus.ld_hit, bus.ld_data, bus.ld_stall);
        end
`else
        checks++;
        if (bus.ld_stall !== 1'b1 || bus.ld_hit !== 1'b0 || bus.ld_data !== 32'h0) begin
            errors++; $display("FAIL fwd_stall got stall %b hit %b data %h exp 1 0 0",
                               bus.ld_stall, bus.ld_hit, bus.ld_data);
        end
`endif
        bus.ld_valid = 1'b0;
        #1;
        checks++;
        if (bus.ld_hit !== 1'b0 || bus.ld_stall !== 1'b0 || bus.ld_data !== 32'h0) begin
            errors++; $display("FAIL fwd_ld_invalid got hit %b stall %b data %h exp 0 0 0",
                               bus.ld_hit, bus.ld_stall, bus.ld_data);
        end
        bus.ld_valid     = 1'b1;
        bus.mem_wr_ready = 1'b1;
        #1;
`ifndef STORE_FWD_EN
        checks++;
        if (bus.ld_stall !== 1'b1) begin
            errors++; $display("FAIL fwd_deq_cycle_stall got %b exp 1", bus.ld_stall);
        end
`endif
        tick();
        checks++;
        if (bus.count !== 3'd0 || bus.ld_stall !== 1'b0 || bus.ld_hit !== 1'b0) begin
            errors++; $display("FAIL fwd_after_drain got count %0d stall %b hit %b exp 0 0 0",
                               bus.count, bus.ld_stall, bus.ld_hit);
        end
        bus.ld_valid     = 1'b0;
        bus.mem_wr_ready = 1'b0;
    endtask

    task automatic test_partial();
        bus.mem_wr_ready = 1'b0;
        push(OP_SB, 32'h20, 32'hAB);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h20;
        #1;
        checks++;
        if (bus.ld_stall !== 1'b1 || bus.ld_hit !== 1'b0) begin
            errors++; $display("FAIL partial_stall got stall %b hit %b exp 1 0", bus.ld_stall, bus.ld_hit);
        end
        bus.ld_addr = 32'h24;
        #1;
        checks++;
        if (bus.ld_stall !== 1'b0 || bus.ld_hit !== 1'b0) begin
            errors++; $display("FAIL partial_nomatch got stall %b hit %b exp 0 0", bus.ld_stall, bus.ld_hit);
        end
        bus.ld_addr      = 32'h20;
        bus.mem_wr_ready = 1'b1;
        #1;
        checks++;
        if (bus.ld_stall !== 1'b1 || bus.mem_opcode !== OP_SB) begin
            errors++; $display("FAIL partial_deq_cycle got stall %b op %h exp 1 28", bus.ld_stall, bus.mem_opcode);
        end
        tick();
        checks++;
        if (bus.ld_stall !== 1'b0 || bus.count !== 3'd0) begin
            errors++; $display("FAIL partial_released got stall %b count %0d exp 0 0", bus.ld_stall, bus.count);
        end
        bus.ld_valid     = 1'b0;
        bus.mem_wr_ready = 1'b0;
    endtask

    task automatic test_youngest();
        bus.mem_wr_ready = 1'b0;
        push(OP_SW, 32'h30, 32'h1);
        push(OP_SW, 32'h30, 32'h2);
        push(6'h23, 32'h30, 32'h3);
        checks++;
        if (bus.count !== 3'd2 || bus.st_ready !== 1'b1) begin
            errors++; $display("FAIL illegal_op got count %0d ready %b exp 2 1", bus.count, bus.st_ready);
        end
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h30;
        #1;
`ifdef STORE_FWD_EN
        checks++;
        if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'h2) begin
            errors++; $display("FAIL youngest_data got hit %b data %h exp 1 2", bus.ld_hit, bus.ld_data);
        end
`else
        checks++;
        if (bus.ld_stall !== 1'b1 || bus.ld_data !== 32'h0) begin
            errors++; $display("FAIL youngest_stall got stall %b data %h exp 1 0", bus.ld_stall, bus.ld_data);
        end
`endif
        bus.mem_wr_ready = 1'b1;
        tick();
`ifdef STORE_FWD_EN
        checks++;
        if (bus.count !== 3'd1 || bus.ld_hit !== 1'b1 || bus.ld_data !== 32'h2) begin
            errors++; $display("FAIL youngest_one_left got count %0d hit %b data %h exp 1 1 2",
                               bus.count, bus.ld_hit, bus.ld_data);
        end
`else
        checks++;
        if (bus.count !== 3'd1 || bus.ld_stall !== 1'b1) begin
            errors++; $display("FAIL youngest_one_left got count %0d stall %b exp 1 1", bus.count, bus.ld_stall);
        end
`endif
        tick();
        checks++;
        if (bus.count !== 3'd0 || bus.ld_stall !== 1'b0 || bus.ld_hit !== 1'b0) begin
            errors++; $display("FAIL youngest_drained got count %0d stall %b hit %b exp 0 0 0",
                               bus.count, bus.ld_stall, bus.ld_hit);
        end
        checks++;
        if (wr_log.size() < 2 || wr_log[wr_log.size()-1] !== 32'h30) begin
            errors++; $display("FAIL youngest_writes got %0d writes exp last addr 30", wr_log.size());
        end
        bus.ld_valid     = 1'b0;
        bus.mem_wr_ready = 1'b0;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        bus.st_valid     = 1'b0;
        bus.st_addr      = '0;
        bus.st_data      = '0;
        bus.st_opcode    = '0;
        bus.ld_valid     = 1'b0;
        bus.ld_addr      = '0;
        bus.mem_wr_ready = 1'b0;
        #12;
        test_reset();
        test_reset_mid_drain();
        test_fill();
        test_back_to_back();
        test_forward();
        test_partial();
        test_youngest();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
